ysyx_22050133_mem_arbiter: RTL and testbench

- Shares the single AXI-side rw port (the `axi_rw_*` / `axi_w_*` / `axi_r_*` bundle driven by each cache) between two cache requesters.
- Requester m0 is the instruction cache and m1 is the data cache; the slave side s_* connects to the AXI master bridge.
- Grants one complete burst at a time: address phase, then all write beats or all read beats.
- Uses round-robin priority between the two requesters.

---
 rtl/ysyx_22050133_mem_arbiter.sv | 168 ++++++++++++++++
 tb/tb_ysyx_22050133_mem_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22050133_mem_arbiter.sv
// Round-robin arbiter sharing one AXI rw port between icache (m0) and dcache (m1), one whole burst per grant.
// Grant adds one idle cycle; beats are forwarded combinationally with downstream backpressure passed to the owner.
module ysyx_22050133_mem_arbiter #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  m0_rw_addr_valid_i,
    output logic                  m0_rw_addr_ready_o,
    input  logic [ADDR_WIDTH-1:0] m0_rw_addr_i,
    input  logic                  m0_rw_we_i,
    input  logic [7:0]            m0_rw_len_i,
    input  logic [2:0]            m0_rw_size_i,
    input  logic [1:0]            m0_rw_burst_i,
    input  logic                  m0_rw_if_i,
    input  logic                  m0_w_data_valid_i,
    output logic                  m0_w_data_ready_o,
    input  logic [DATA_WIDTH-1:0] m0_w_data_i,
    output logic                  m0_r_data_valid_o,
    input  logic                  m0_r_data_ready_i,
    output logic [DATA_WIDTH-1:0] m0_r_data_o,

    input  logic                  m1_rw_addr_valid_i,
    output logic                  m1_rw_addr_ready_o,
    input  logic [ADDR_WIDTH-1:0] m1_rw_addr_i,
    input  logic                  m1_rw_we_i,
    input  logic [7:0]            m1_rw_len_i,
    input  logic [2:0]            m1_rw_size_i,
    input  logic [1:0]            m1_rw_burst_i,
    input  logic                  m1_rw_if_i,
    input  logic                  m1_w_data_valid_i,
    output logic                  m1_w_data_ready_o,
    input  logic [DATA_WIDTH-1:0] m1_w_data_i,
    output logic                  m1_r_data_valid_o,
    input  logic                  m1_r_data_ready_i,
    output logic [DATA_WIDTH-1:0] m1_r_data_o,

    output logic                  s_rw_addr_valid_o,
    input  logic                  s_rw_addr_ready_i,
    output logic [ADDR_WIDTH-1:0] s_rw_addr_o,
    output logic                  s_rw_we_o,
    output logic [7:0]            s_rw_len_o,
    output logic [2:0]            s_rw_size_o,
    output logic [1:0]            s_rw_burst_o,
    output logic                  s_rw_if_o,
    output logic                  s_w_data_valid_o,
    input  logic                  s_w_data_ready_i,
    output logic [DATA_WIDTH-1:0] s_w_data_o,
    input  logic                  s_r_data_valid_i,
    output logic                  s_r_data_ready_o,
    input  logic [DATA_WIDTH-1:0] s_r_data_i,

    output logic [1:0]            grant_o
);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_W, S_R} state_t;

    state_t     state, state_nxt;
    logic       owner, owner_nxt;
    logic       last, last_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic       we_q, we_nxt;
    logic       winner;

    logic       own_addr_valid;
    logic       own_we;
    logic [7:0] own_len;
    logic       own_w_valid;
    logic       own_r_ready;
    logic       in_addr, in_w, in_r;

    assign own_addr_valid = owner ? m1_rw_addr_valid_i : m0_rw_addr_valid_i;
    assign own_we         = owner ? m1_rw_we_i         : m0_rw_we_i;
    assign own_len        = owner ? m1_rw_len_i        : m0_rw_len_i;
    assign own_w_valid    = owner ? m1_w_data_valid_i  : m0_w_data_valid_i;
    assign own_r_ready    = owner ? m1_r_data_ready_i  : m0_r_data_ready_i;

    // we_q keeps the data phase tied to the direction latched at the address handshake
    assign in_addr = (state == S_ADDR);
    assign in_w    = (state == S_W) &&  we_q;
    assign in_r    = (state == S_R) && !we_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            owner <= 1'b0;
            last  <= 1'b1;
            cnt   <= 8'd0;
            we_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
            last  <= last_nxt;
            cnt   <= cnt_nxt;
            we_q  <= we_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        last_nxt  = last;
        cnt_nxt   = cnt;
        we_nxt    = we_q;
        winner    = m1_rw_addr_valid_i;
        unique case (state)
            S_IDLE: begin
                if (m0_rw_addr_valid_i && m1_rw_addr_valid_i) begin
                    winner = ~last;
                end
                if (m0_rw_addr_valid_i || m1_rw_addr_valid_i) begin
                    owner_nxt = winner;
                    last_nxt  = winner;
                    state_nxt = S_ADDR;
                end
            end
            S_ADDR: begin
                if (!own_addr_valid) begin
                    state_nxt = S_IDLE;
                end else if (s_rw_addr_ready_i) begin
                    cnt_nxt   = own_len;
                    we_nxt    = own_we;
                    state_nxt = own_we ? S_W : S_R;
                end
            end
            S_W: begin
                if (own_w_valid && s_w_data_ready_i) begin
                    if (cnt == 8'd0) state_nxt = S_IDLE;
                    else             cnt_nxt   = cnt - 8'd1;
                end
            end
            S_R: begin
                if (s_r_data_valid_i && own_r_ready) begin
                    if (cnt == 8'd0) state_nxt = S_IDLE;
                    else             cnt_nxt   = cnt - 8'd1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign s_rw_addr_valid_o  = in_addr && own_addr_valid;
    assign s_rw_addr_o        = owner ? m1_rw_addr_i  : m0_rw_addr_i;
    assign s_rw_we_o          = own_we;
    assign s_rw_len_o         = own_len;
    assign s_rw_size_o        = owner ? m1_rw_size_i  : m0_rw_size_i;
    assign s_rw_burst_o       = owner ? m1_rw_burst_i : m0_rw_burst_i;
    assign s_rw_if_o          = owner ? m1_rw_if_i    : m0_rw_if_i;

    assign m0_rw_addr_ready_o = in_addr && !owner && s_rw_addr_ready_i;
    assign m1_rw_addr_ready_o = in_addr &&  owner && s_rw_addr_ready_i;

    assign s_w_data_valid_o   = in_w && own_w_valid;
    assign s_w_data_o         = owner ? m1_w_data_i : m0_w_data_i;
    assign m0_w_data_ready_o  = in_w && !owner && s_w_data_ready_i;
    assign m1_w_data_ready_o  = in_w &&  owner && s_w_data_ready_i;

    assign m0_r_data_valid_o  = in_r && !owner && s_r_data_valid_i;
    assign m1_r_data_valid_o  = in_r &&  owner && s_r_data_valid_i;
    assign s_r_data_ready_o   = in_r && own_r_ready;
    assign m0_r_data_o        = s_r_data_i;
    assign m1_r_data_o        = s_r_data_i;

    assign grant_o = (state == S_IDLE) ? 2'b00 : (owner ? 2'b10 : 2'b01);

endmodule

// File: tb/tb_ysyx_22050133_mem_arbiter.sv
// Directed bench for the two-requester burst arbiter: per-cycle vector table plus multi-cycle burst sequences.
module tb_ysyx_22050133_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_av, m0_ar, m0_we, m0_if, m0_wv, m0_wr, m0_rv, m0_rr;
    logic [31:0] m0_addr;
    logic [7:0]  m0_len;
    logic [63:0] m0_wd, m0_rd;
    logic        m1_av, m1_ar, m1_we, m1_if, m1_wv, m1_wr, m1_rv, m1_rr;
    logic [31:0] m1_addr;
    logic [7:0]  m1_len;
    logic [63:0] m1_wd, m1_rd;
    logic        s_av, s_ar, s_we, s_if, s_wv, s_wr, s_rv, s_rr;
    logic [31:0] s_addr;
    logic [7:0]  s_len;
    logic [2:0]  s_size;
    logic [1:0]  s_burst;
    logic [63:0] s_wd, s_rd;
    logic [1:0]  grant;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ysyx_22050133_mem_arbiter #(.DATA_WIDTH(64), .ADDR_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_rw_addr_valid_i(m0_av), .m0_rw_addr_ready_o(m0_ar), .m0_rw_addr_i(m0_addr),
        .m0_rw_we_i(m0_we), .m0_rw_len_i(m0_len), .m0_rw_size_i(3'd3), .m0_rw_burst_i(2'd1),
        .m0_rw_if_i(m0_if), .m0_w_data_valid_i(m0_wv), .m0_w_data_ready_o(m0_wr),
        .m0_w_data_i(m0_wd), .m0_r_data_valid_o(m0_rv), .m0_r_data_ready_i(m0_rr),
        .m0_r_data_o(m0_rd),
        .m1_rw_addr_valid_i(m1_av), .m1_rw_addr_ready_o(m1_ar), .m1_rw_addr_i(m1_addr),
        .m1_rw_we_i(m1_we), .m1_rw_len_i(m1_len), .m1_rw_size_i(3'd2), .m1_rw_burst_i(2'd1),
        .m1_rw_if_i(m1_if), .m1_w_data_valid_i(m1_wv), .m1_w_data_ready_o(m1_wr),
        .m1_w_data_i(m1_wd), .m1_r_data_valid_o(m1_rv), .m1_r_data_ready_i(m1_rr),
        .m1_r_data_o(m1_rd),
        .s_rw_addr_valid_o(s_av), .s_rw_addr_ready_i(s_ar), .s_rw_addr_o(s_addr),
        .s_rw_we_o(s_we), .s_rw_len_o(s_len), .s_rw_size_o(s_size), .s_rw_burst_o(s_burst),
        .s_rw_if_o(s_if), .s_w_data_valid_o(s_wv), .s_w_data_ready_i(s_wr),
        .s_w_data_o(s_wd), .s_r_data_valid_i(s_rv), .s_r_data_ready_o(s_rr),
        .s_r_data_i(s_rd),
        .grant_o(grant)
    );

    // inputs: m0_av m1_av m0_we m1_we len s_ar s_rv s_wr m0_wv m1_wv m0_rr m1_rr
    // exp   : {grant[1:0], s_av, m0_ar, m1_ar, m0_rv, m1_rv, s_wv, m0_wr, m1_wr, s_rr}
    typedef struct packed {
        logic        m0_av, m1_av, m0_we, m1_we;
        logic [7:0]  len;
        logic        s_ar, s_rv, s_wr, m0_wv, m1_wv, m0_rr, m1_rr;
        logic [10:0] exp;
    } vec_t;

    vec_t vec [15];

    function automatic logic [10:0] obs();
        return {grant, s_av, m0_ar, m1_ar, m0_rv, m1_rv, s_wv, m0_wr, m1_wr, s_rr};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clr();
        m0_av = 0; m0_we = 0; m0_if = 1; m0_wv = 0; m0_rr = 0; m0_addr = '0; m0_len = '0; m0_wd = '0;
        m1_av = 0; m1_we = 0; m1_if = 0; m1_wv = 0; m1_rr = 0; m1_addr = '0; m1_len = '0; m1_wd = '0;
        s_ar = 0; s_wr = 0; s_rv = 0; s_rd = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int beats;
        logic [63:0] exp_d;

        vec[0]  = '{1'b1,1'b1,1'b0,1'b0,8'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 11'b00000000000};
        vec[1]  = '{1'b1,1'b1,1'b0,1'b0,8'd0, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 11'b01110000000};
        vec[2]  = '{1'b0,1'b1,1'b0,1'b0,8'd0, 1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,1'b0, 11'b01000100001};
        vec[3]  = '{1'b0,1'b1,1'b0,1'b1,8'd1, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 11'b00000000000};
        vec[4]  = '{1'b0,1'b1,1'b0,1'b1,8'd1, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 11'b10101000000};
        vec[5]  = '{1'b0,1'b0,1'b0,1'b0,8'd0, 1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0, 11'b10000001010};
        vec[6]  = '{1'b0,1'b0,1'b0,1'b0,8'd0, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 11'b10000001000};
        vec[7]  = '{1'b0,1'b0,1'b0,1'b0,8'd0, 1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0, 11'b10000001010};
        vec[8]  = '{1'b1,1'b1,1'b0,1'b0,8'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 11'b00000000000};
        vec[9]  = '{1'b1,1'b1,1'b0,1'b0,8'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 11'b01100000000};
        vec[10] = '{1'b0,1'b1,1'b0,1'b0,8'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 11'b01000000000};
        vec[11] = '{1'b1,1'b1,1'b0,1'b0,8'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 11'b00000000000};
        vec[12] = '{1'b1,1'b1,1'b0,1'b0,8'd0, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 11'b10101000000};
        vec[13] = '{1'b0,1'b0,1'b0,1'b0,8'd0, 1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,1'b1, 11'b10000010001};
        vec[14] = '{1'b0,1'b0,1'b0,1'b0,8'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 11'b00000000000};

        // reset with requests and downstream handshakes active: everything must stay quiet
        clr();
        rst_n = 1'b0;
        m0_av = 1; m1_av = 1; s_ar = 1; s_rv = 1; s_wr = 1; m0_wv = 1; m1_wv = 1; m0_rr = 1; m1_rr = 1;
        #3;
        chk("reset_outputs", {53'd0, obs()}, 64'd0);
        step();
        clr();
        step();
        rst_n = 1'b1;

        // per-cycle table: tie-break, len=0 read, write backpressure, owner drop, alternation
        for (int i = 0; i < 15; i++) begin
            step();
            m0_av = vec[i].m0_av; m1_av = vec[i].m1_av;
            m0_we = vec[i].m0_we; m1_we = vec[i].m1_we;
            m0_len = vec[i].len;  m1_len = vec[i].len;
            s_ar = vec[i].s_ar; s_rv = vec[i].s_rv; s_wr = vec[i].s_wr;
            m0_wv = vec[i].m0_wv; m1_wv = vec[i].m1_wv;
            m0_rr = vec[i].m0_rr; m1_rr = vec[i].m1_rr;
            #2;
            chk($sformatf("vec%0d", i), {53'd0, obs()}, {53'd0, vec[i].exp});
        end

        // m0 read of 8 beats at 0x80000000; m1 requests during it and must wait
        step();
        clr();
        m0_av = 1; m0_addr = 32'h8000_0000; m0_len = 8'd7; s_ar = 1;
        #2;
        chk("bubble_addr_valid", {63'd0, s_av}, 64'd0);
        step();
        #2;
        chk("m0_addr_phase", {29'd0, s_av, m0_ar, s_len, s_addr}, {29'd0, 1'b1, 1'b1, 8'd7, 32'h8000_0000});
        for (int i = 0; i < 8; i++) begin
            step();
            clr();
            m1_av = 1; m1_addr = 32'h0000_1000; m1_len = 8'd3;
            s_rv = 1; s_rd = 64'hA5A5_0000_0000_0000 + 64'(i); m0_rr = 1;
            exp_d = 64'hA5A5_0000_0000_0000 + 64'(i);
            #2;
            chk($sformatf("m0_beat%0d_ctl", i), {59'd0, m0_rv, m1_rv, m1_ar, grant},
                {59'd0, 1'b1, 1'b0, 1'b0, 2'b01});
            chk($sformatf("m0_beat%0d_data", i), m0_rd, exp_d);
        end
        step();
        s_rv = 0; m0_rr = 0;
        #2;
        chk("m0_read_done", {62'd0, grant}, 64'd0);

        // m1 read of 4 beats; m0 arrives mid-burst and is stalled until it ends
        step();
        s_ar = 1;
        #2;
        chk("m1_addr_phase", {30'd0, grant, s_addr}, {30'd0, 2'b10, 32'h0000_1000});
        for (int i = 0; i < 4; i++) begin
            step();
            clr();
            m0_av = 1; m0_addr = 32'h8000_2000; m0_we = 1; m0_len = 8'd255;
            s_rv = 1; s_rd = 64'h0BAD_F00D_0000_0000 + 64'(i); m1_rr = 1;
            #2;
            chk($sformatf("m1_beat%0d_ctl", i), {58'd0, m1_rv, m0_rv, m0_ar, s_rr, grant},
                {58'd0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b10});
        end
        step();
        s_rv = 0; m1_rr = 0;
        #2;
        chk("m0_stalled_idle", {61'd0, m0_ar, grant}, 64'd0);

        // m0 write of 256 beats with ready toggling; must exit only after the last handshake
        step();
        s_ar = 1;
        #2;
        chk("m0_w_addr_phase", {29'd0, grant, m0_ar, s_we, s_len, s_addr[23:0]},
            {29'd0, 2'b01, 1'b1, 1'b1, 8'd255, 24'h00_2000});
        beats = 0;
        for (int c = 0; c < 600; c++) begin
            step();
            clr();
            m0_wv = 1; m0_wd = {32'hC0DE_0000, 32'(beats)}; s_wr = c[0];
            #2;
            if (grant == 2'b00) break;
            chk("w256_data", {s_wv, s_wd}, {1'b1, 32'hC0DE_0000, 32'(beats)});
            if (s_wv && s_wr) beats++;
        end
        chk("w256_beats", 64'(beats), 64'd256);
        chk("w256_idle", {62'd0, grant}, 64'd0);

        // reset during the third beat of an m1 write
        clr();
        m1_av = 1; m1_we = 1; m1_len = 8'd7;
        step();
        s_ar = 1;
        #2;
        chk("rst_w_addr", {62'd0, grant}, {62'd0, 2'b10});
        for (int i = 0; i < 2; i++) begin
            step();
            clr();
            m1_wv = 1; m1_wd = 64'(i); s_wr = 1;
        end
        step();
        m1_wv = 1; s_wr = 1; s_rv = 1; m0_rr = 1; m1_rr = 1; m0_av = 1;
        #2;
        chk("rst_w_beat3", {62'd0, s_wv, m1_wr}, {62'd0, 2'b11});
        rst_n = 1'b0;
        #1;
        chk("rst_async_outputs", {53'd0, obs()}, 64'd0);
        step();
        clr();
        rst_n = 1'b1;
        #2;
        chk("rst_release_idle", {61'd0, s_av, grant}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
